// File: rtl/counter_seq_ctrl_if.sv
// Command channel for counter_seq_ctrl.
// Carries the valid/ready handshake plus opcode and operand.
interface counter_seq_ctrl_if #(
    parameter int DIV_W = 26
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [DIV_W-1:0] cmd_data;

    modport master (
        output cmd_valid, cmd_op, cmd_data,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data,
        output cmd_ready
    );
endinterface

// File: rtl/counter_seq_ctrl.sv
// Command-driven sequencer for the prescaled up/down 4-bit counter.
// Owns the prescaler, the divide register and the count itself.
module counter_seq_ctrl #(
    parameter int CNT_W   = 4,
    parameter int DIV_W   = 26,
    parameter int DIV_RST = 49_999_999
) (
    input  logic               clk,
    input  logic               reset,
    counter_seq_ctrl_if.slave  cmd,
    output logic [CNT_W-1:0]   out,
    output logic               tick,
    output logic               running,
    output logic               done
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam logic [1:0] OP_STOP  = 2'b00;
    localparam logic [1:0] OP_START = 2'b01;
    localparam logic [1:0] OP_LOAD  = 2'b10;
    localparam logic [1:0] OP_SDIV  = 2'b11;

    state_t           state, state_n;
    logic [DIV_W-1:0] pre, pre_n;
    logic [DIV_W-1:0] div_reg, div_n;
    logic             dir, dir_n;
    logic             oneshot, os_n;
    logic [CNT_W-1:0] out_n;
    logic             done_n;
    logic             accept;
    logic [CNT_W-1:0] step;
    logic [CNT_W-1:0] term;

    // Only STOP may interrupt a running count; everything else stalls.
    assign cmd.cmd_ready = (state != RUN) || (cmd.cmd_op == OP_STOP);
    assign accept  = cmd.cmd_valid && cmd.cmd_ready;
    assign running = (state == RUN);
    assign tick    = (state == RUN) && (pre == div_reg);
    assign step    = dir ? out + CNT_W'(1) : out - CNT_W'(1);
    assign term    = dir ? '1 : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            pre     <= '0;
            div_reg <= DIV_W'(DIV_RST);
            dir     <= 1'b1;
            oneshot <= 1'b0;
            out     <= '0;
            done    <= 1'b0;
        end else begin
            state   <= state_n;
            pre     <= pre_n;
            div_reg <= div_n;
            dir     <= dir_n;
            oneshot <= os_n;
            out     <= out_n;
            done    <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        pre_n   = pre;
        div_n   = div_reg;
        dir_n   = dir;
        os_n    = oneshot;
        out_n   = out;
        done_n  = 1'b0;
        // An accepted command always beats a coincident tick.
        if (accept) begin
            unique case (cmd.cmd_op)
                OP_STOP: state_n = IDLE;
                OP_START: begin
                    dir_n   = cmd.cmd_data[0];
                    os_n    = cmd.cmd_data[1];
                    pre_n   = '0;
                    state_n = RUN;
                end
                OP_LOAD: begin
                    out_n   = cmd.cmd_data[CNT_W-1:0];
                    state_n = IDLE;
                end
                OP_SDIV: div_n = cmd.cmd_data;
                default: ;
            endcase
        end else if (state == RUN) begin
            if (tick) begin
                pre_n = '0;
                out_n = step;
                if (step == term) begin
                    done_n = 1'b1;
                    if (oneshot) state_n = HALT;
                end
            end else begin
                pre_n = pre + DIV_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Directed bench for counter_seq_ctrl.
// Each task drives one scenario and checks hand-computed values.
module tb_counter_seq_ctrl;
    localparam int CNT_W = 4;
    localparam int DIV_W = 26;
    localparam logic [DIV_W-1:0] DIV_RST = 26'd49_999_999;

    logic             clk;
    logic             reset;
    logic [CNT_W-1:0] out;
    logic             tick;
    logic             running;
    logic             done;

    int n_cmp;
    int n_err;

    counter_seq_ctrl_if #(.DIV_W(DIV_W)) bus ();

    counter_seq_ctrl #(
        .CNT_W(CNT_W),
        .DIV_W(DIV_W),
        .DIV_RST(49_999_999)
    ) dut (
        .clk(clk),
        .reset(reset),
        .cmd(bus),
        .out(out),
        .tick(tick),
        .running(running),
        .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [1:0] op, input logic [DIV_W-1:0] d);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_data  = d;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op = 2'b00;
        bus.cmd_data = '0;
        #19;
        n_cmp++;
        if (out !== 4'd0) begin
            n_err++;
            $display("FAIL rst_out got %0d want 0", out);
        end
        n_cmp++;
        if (running !== 1'b0 || tick !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL rst_flags got r%b t%b d%b want 000", running, tick, done);
        end
        n_cmp++;
        if (dut.div_reg !== DIV_RST) begin
            n_err++;
            $display("FAIL rst_div got %0d want %0d", dut.div_reg, DIV_RST);
        end
        n_cmp++;
        if (bus.cmd_ready !== 1'b1) begin
            n_err++;
            $display("FAIL rst_ready got %b want 1", bus.cmd_ready);
        end
        #1;
        reset = 1'b0;
        cyc(1);
    endtask

    task automatic test_up_wrap;
        send(2'b11, 26'd3);
        send(2'b01, 26'd1);
        n_cmp++;
        if (running !== 1'b1 || out !== 4'd0) begin
            n_err++;
            $display("FAIL up_start got r%b out %0d want r1 out 0", running, out);
        end
        cyc(3);
        n_cmp++;
        if (tick !== 1'b1 || out !== 4'd0) begin
            n_err++;
            $display("FAIL up_tick1 got t%b out %0d want t1 out 0", tick, out);
        end
        cyc(1);
        n_cmp++;
        if (out !== 4'd1 || done !== 1'b0) begin
            n_err++;
            $display("FAIL up_first got out %0d d%b want 1 d0", out, done);
        end
        for (int i = 2; i < 16; i++) begin
            cyc(4);
            n_cmp++;
            if (out !== 4'(i) || done !== (i == 15)) begin
                n_err++;
                $display("FAIL up_step%0d got out %0d d%b want %0d d%b",
                         i, out, done, i, (i == 15));
            end
        end
        cyc(1);
        n_cmp++;
        if (done !== 1'b0 || out !== 4'd15) begin
            n_err++;
            $display("FAIL up_donelen got out %0d d%b want 15 d0", out, done);
        end
        cyc(3);
        n_cmp++;
        if (out !== 4'd0 || done !== 1'b0 || running !== 1'b1) begin
            n_err++;
            $display("FAIL up_wrap got out %0d d%b r%b want 0 d0 r1", out, done, running);
        end
        send(2'b00, 26'd0);
        n_cmp++;
        if (running !== 1'b0 || out !== 4'd0) begin
            n_err++;
            $display("FAIL up_stop got r%b out %0d want r0 out 0", running, out);
        end
    endtask

    task automatic test_oneshot_down;
        send(2'b10, 26'd5);
        send(2'b11, 26'd0);
        send(2'b01, 26'd2);
        for (int i = 1; i <= 5; i++) begin
            cyc(1);
            n_cmp++;
            if (out !== 4'(5 - i) || done !== (i == 5) || running !== (i < 5)) begin
                n_err++;
                $display("FAIL dn_step%0d got out %0d d%b r%b want %0d d%b r%b",
                         i, out, done, running, 5 - i, (i == 5), (i < 5));
            end
        end
        cyc(3);
        n_cmp++;
        if (out !== 4'd0 || done !== 1'b0 || running !== 1'b0 || tick !== 1'b0) begin
            n_err++;
            $display("FAIL dn_halt got out %0d d%b r%b t%b want 0 0 0 0",
                     out, done, running, tick);
        end
    endtask

    task automatic test_stall_stop;
        send(2'b11, 26'd7);
        send(2'b01, 26'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'b10;
        bus.cmd_data  = 26'd9;
        #1;
        n_cmp++;
        if (bus.cmd_ready !== 1'b0) begin
            n_err++;
            $display("FAIL st_stall got ready %b want 0", bus.cmd_ready);
        end
        cyc(2);
        n_cmp++;
        if (bus.cmd_ready !== 1'b0 || out !== 4'd0 || running !== 1'b1) begin
            n_err++;
            $display("FAIL st_hold got rdy %b out %0d r%b want 0 0 1",
                     bus.cmd_ready, out, running);
        end
        bus.cmd_op = 2'b00;
        #1;
        n_cmp++;
        if (bus.cmd_ready !== 1'b1) begin
            n_err++;
            $display("FAIL st_stoprdy got ready %b want 1", bus.cmd_ready);
        end
        cyc(1);
        n_cmp++;
        if (running !== 1'b0 || out !== 4'd0) begin
            n_err++;
            $display("FAIL st_stop got r%b out %0d want r0 out 0", running, out);
        end
        bus.cmd_op = 2'b10;
        bus.cmd_data = 26'd9;
        cyc(1);
        bus.cmd_valid = 1'b0;
        n_cmp++;
        if (out !== 4'd9 || running !== 1'b0) begin
            n_err++;
            $display("FAIL st_load got out %0d r%b want 9 r0", out, running);
        end
    endtask

    task automatic test_collision;
        send(2'b11, 26'd2);
        send(2'b10, 26'd6);
        send(2'b01, 26'd1);
        cyc(2);
        n_cmp++;
        if (tick !== 1'b1 || out !== 4'd6) begin
            n_err++;
            $display("FAIL col_tick got t%b out %0d want t1 out 6", tick, out);
        end
        send(2'b00, 26'd0);
        n_cmp++;
        if (out !== 4'd6 || done !== 1'b0 || running !== 1'b0 || tick !== 1'b0) begin
            n_err++;
            $display("FAIL col_stop got out %0d d%b r%b t%b want 6 0 0 0",
                     out, done, running, tick);
        end
        cyc(1);
        n_cmp++;
        if (out !== 4'd6 || done !== 1'b0) begin
            n_err++;
            $display("FAIL col_after got out %0d d%b want 6 d0", out, done);
        end
    endtask

    task automatic test_async_reset;
        send(2'b10, 26'd0);
        send(2'b11, 26'd7);
        send(2'b01, 26'd1);
        cyc(24);
        n_cmp++;
        if (out !== 4'd3 || running !== 1'b1) begin
            n_err++;
            $display("FAIL ar_pre got out %0d r%b want 3 r1", out, running);
        end
        #2;
        reset = 1'b1;
        #1;
        n_cmp++;
        if (out !== 4'd0 || running !== 1'b0 || done !== 1'b0 || tick !== 1'b0) begin
            n_err++;
            $display("FAIL ar_now got out %0d r%b d%b t%b want 0 0 0 0",
                     out, running, done, tick);
        end
        n_cmp++;
        if (dut.div_reg !== DIV_RST) begin
            n_err++;
            $display("FAIL ar_div got %0d want %0d", dut.div_reg, DIV_RST);
        end
        #1;
        reset = 1'b0;
        cyc(1);
    endtask

    task automatic test_wrap_edge;
        send(2'b11, 26'd0);
        send(2'b10, 26'd15);
        send(2'b01, 26'd3);
        for (int i = 1; i <= 16; i++) begin
            cyc(1);
            n_cmp++;
            if (out !== 4'(i - 1) || done !== (i == 16) || running !== (i < 16)) begin
                n_err++;
                $display("FAIL we_step%0d got out %0d d%b r%b want %0d d%b r%b",
                         i, out, done, running, i - 1, (i == 16), (i < 16));
            end
        end
        cyc(2);
        n_cmp++;
        if (out !== 4'd15 || done !== 1'b0 || running !== 1'b0) begin
            n_err++;
            $display("FAIL we_halt got out %0d d%b r%b want 15 0 0", out, done, running);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_up_wrap();
        test_oneshot_down();
        test_stall_stop();
        test_collision();
        test_async_reset();
        test_wrap_edge();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/counter_seq_ctrl.md
# counter_seq_ctrl

Command-driven controller that sequences the workshop's clock-divided 4-bit counter. It owns the prescaler that generates the count enable and the count register itself. It accepts START/STOP/LOAD/SET_DIV commands over a valid/ready handshake, and supports up/down and wrap/one-shot modes. It sits between board-level control logic (buttons, UART decoder) and the LED/7-segment display path that consumes `out`.

## Interface
- `CNT_W`, 4: count width.
- `DIV_W`, 26: prescaler and divide-register width.
- `DIV_RST`, 49_999_999: divide value after reset (1 Hz tick at 50 MHz).

- `clk`  in  1  single system clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  command accepted when `cmd_valid && cmd_ready` at a rising edge.
- `cmd_op`  in  2  00 STOP, 01 START, 10 LOAD, 11 SET_DIV.
- `cmd_data`  in  DIV_W  operand. START uses bit0 = direction (1 up, 0 down) and bit1 = one-shot. LOAD uses `[CNT_W-1:0]`. SET_DIV uses all bits.
- `out`  out  CNT_W  current count.
- `tick`  out  1  count-enable strobe (combinational).
- `running`  out  1  state == RUN.
- `done`  out  1  one-cycle pulse when the count reaches its terminal value.

## Operation
- Registers:
  - `state` in {IDLE, RUN, HALT}
  - `pre` (DIV_W bits)
  - `div_reg`
  - `dir`
  - `oneshot`
  - `out`
  - `done`
- Reset values: state=IDLE, pre=0, div_reg=DIV_RST, dir=1, oneshot=0, out=0, done=0, running=0, tick=0.
- `cmd_ready` is combinational:
  - IDLE/HALT: 1 for all ops.
  - RUN: 1 only when `cmd_op`==STOP. Other ops stall until the state leaves RUN.
- STOP:
  - RUN → IDLE; `out` is held.
  - In IDLE or HALT, STOP has no effect except HALT → IDLE.
- START:
  - Latches `dir` and `oneshot` from `cmd_data[1:0]`, clears `pre`, and sets state → RUN.
  - `out` keeps its value.
- LOAD: `out` ← `cmd_data[CNT_W-1:0]`; state → IDLE.
- SET_DIV: `div_reg` ← `cmd_data`. It takes effect at the next START because `pre` is cleared then.
- Prescaler, in RUN only:
  - `tick` = (`pre` == `div_reg`).
  - When tick is high: `pre` ← 0 and `out` steps ±1 modulo 2^CNT_W.
  - Otherwise: `pre` ← `pre`+1.
  - Tick period is `div_reg`+1 cycles; `div_reg`=0 gives a tick every cycle.
- Terminal value: all-ones when `dir`=1, zero when `dir`=0.
  - When a tick makes `out` equal the terminal value, `done` is high for the following cycle.
  - One-shot: at that same edge, state → HALT and counting stops.
  - Wrap mode: counting continues through wrap-around (15→0 or 0→15), and `done` pulses each time the terminal value is reached.
- START while `out` is already at the terminal value: counting proceeds and wraps. In one-shot, it halts on the next arrival at the terminal value (2^CNT_W ticks later).
- Simultaneous STOP and tick in the same cycle: STOP wins. `out` does not step, no `done` pulse occurs, and state → IDLE.
- `reset` asserted at any time, including mid-RUN: all registers return to reset values asynchronously. `div_reg` also returns to DIV_RST.

## Timing
- START accepted at edge k:
  - `running`=1 from k.
  - First `tick` in the cycle before edge k+`div_reg`+1.
  - First `out` change at edge k+`div_reg`+1.
- Command-to-effect latency is one edge for all ops; there is no internal pipeline.
- `done` is registered: high for exactly one cycle, starting at the edge where `out` takes the terminal value.
- `tick` is combinational from registers and is never high outside RUN.

## Test plan
- Reset and configuration check:
  - Stimulus: assert `reset` for 20 ns, then SET_DIV 3 and START up/wrap (`cmd_data`=1).
  - Required response:
    - After reset: `out`=0, `running`=0.
    - `out` steps 0→1→2… every 4 cycles.
    - First increment 4 edges after START.
    - `done` pulses when `out`=15; the next value is 0.
- One-shot down count:
  - Stimulus: LOAD 5, SET_DIV 0, START down/one-shot (`cmd_data`=2).
  - Required response: `out` goes 4,3,2,1,0 on consecutive edges; `done` pulses once; state HALT with `running`=0; `out` holds 0.
- Stall and STOP:
  - Stimulus: during RUN, drive LOAD 9; then STOP.
  - Required response: `cmd_ready`=0 for LOAD while running. STOP is accepted immediately and `out` freezes. The pending LOAD is accepted the next cycle, giving `out`=9.
- Collision:
  - Stimulus: with `div_reg`=2, issue STOP in the exact cycle `tick`=1.
  - Required response: `out` unchanged, no `done`, state IDLE.
- Asynchronous reset mid-run:
  - Stimulus: SET_DIV 7, START, then pulse `reset` between clock edges at `out`=3.
  - Required response: `out`=0, `running`=0, `div_reg`=DIV_RST, all immediately, without waiting for a clock edge.
- Wrap edge:
  - Stimulus: LOAD 15, START up/one-shot with `div_reg`=0.
  - Required response: `out` wraps to 0 and counts 1…15; `done` pulses only at the final 15, 16 edges later; then HALT.
